// File: rtl/dm_trace_mem.sv
// dm_trace_mem: word-organised data memory for the M-stage data port.
//   - Byte-enable merge on write, read on the same port (RD_LAT 0 or 1).
//   - After reset, a sweep writes 0 to every word while mem_busy is high.
//   - A write whose address falls outside the memory is dropped and sets err_oob.
//   - Every accepted write pushes a {pc, word address, merged word} record
//     into the trace FIFO. A consumer drains it with a valid/ready handshake.
// Ports:
//   clk, reset (async, active low)
//   m_data_addr/m_data_wdata/m_data_byteen/m_inst_addr : M-stage request
//   m_data_rdata : read data
//   mem_busy     : clear sweep in progress
//   err_oob      : sticky out-of-range write flag
//   log_valid/log_ready/log_pc/log_addr/log_data : trace FIFO head
//   log_overflow/log_drop_cnt : lost-record flag and saturating count
module dm_trace_mem #(
    parameter int unsigned DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned RD_LAT    = 0,
    parameter int unsigned LOG_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        mem_busy,
    output logic        err_oob,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_pc,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic        log_overflow,
    output logic [15:0] log_drop_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(LOG_DEPTH);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] clr_ptr;
    logic [31:0]   mem [DEPTH];

    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          run;
    logic          wr;
    logic [31:0]   rd_word;
    logic [31:0]   wr_word;
    logic [31:0]   rd_comb;

    assign off      = m_data_addr - BASE_ADDR;
    assign idx      = off[AW+1:2];
    assign in_range = (off >> 2) < DEPTH;
    assign run      = (state == ST_RUN);
    assign wr       = run & (|m_data_byteen) & in_range;
    assign mem_busy = ~run;
    assign rd_word  = mem[idx];

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign wr_word[8*k +: 8] = m_data_byteen[k] ? m_data_wdata[8*k +: 8]
                                                    : rd_word[8*k +: 8];
    end

    // Clear sweep: one word per edge, leaves for RUN after writing the last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_ptr <= clr_ptr + AW'(1);
            if (clr_ptr == AW'(DEPTH - 1))
                state <= ST_RUN;
        end
    end

    // Array has no reset; the sweep owns the write port until RUN.
    always_ff @(posedge clk) begin
        if (!run)
            mem[clr_ptr] <= '0;
        else if (wr)
            mem[idx] <= wr_word;
    end

    // Read-first falls out naturally: rd_word is sampled before the array updates.
    assign rd_comb = (run && in_range) ? rd_word : '0;

    if (RD_LAT == 0) begin : g_rd0
        assign m_data_rdata = rd_comb;
    end else begin : g_rd1
        logic [31:0] rd_q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) rd_q <= '0;
            else        rd_q <= rd_comb;
        end
        assign m_data_rdata = rd_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_oob <= 1'b0;
        else if (run && (|m_data_byteen) && !in_range)
            err_oob <= 1'b1;
    end

    // Trace FIFO
    logic [31:0] f_pc   [LOG_DEPTH];
    logic [31:0] f_addr [LOG_DEPTH];
    logic [31:0] f_data [LOG_DEPTH];
    logic [LW-1:0] wr_ptr, rd_ptr;
    logic [LW:0]   count;
    logic          full, pop, push_ok, drop;

    assign full    = (count == (LW+1)'(LOG_DEPTH));
    assign pop     = log_valid & log_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok = wr & (~full | pop);
    assign drop    = wr & full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            f_pc[wr_ptr]   <= m_inst_addr;
            f_addr[wr_ptr] <= {m_data_addr[31:2], 2'b00};
            f_data[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            log_overflow <= 1'b0;
            log_drop_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + LW'(1);
            if (pop)     rd_ptr <= rd_ptr + LW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (LW+1)'(1);
                2'b01:   count <= count - (LW+1)'(1);
                default: count <= count;
            endcase
            if (drop) begin
                log_overflow <= 1'b1;
                if (log_drop_cnt != 16'hFFFF)
                    log_drop_cnt <= log_drop_cnt + 16'd1;
            end
        end
    end

    // Head fields read as 0 when empty so reset values are well defined.
    assign log_valid = (count != '0);
    assign log_pc    = log_valid ? f_pc[rd_ptr]   : '0;
    assign log_addr  = log_valid ? f_addr[rd_ptr] : '0;
    assign log_data  = log_valid ? f_data[rd_ptr] : '0;
endmodule

// File: tb/tb_dm_trace_mem.sv
// Bench for dm_trace_mem: two instances (RD_LAT 0 and 1) share all inputs.
// A behavioural model (word array + record queue) predicts every output each cycle.
module tb_dm_trace_mem;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          LOGD  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0, wdata = '0, pc = '0;
    logic [3:0]  byteen = '0;
    logic        ready = 1'b0;

    logic [31:0] rdata0, rdata1, lpc0, lpc1, laddr0, laddr1, ldata0, ldata1;
    logic        busy0, busy1, oob0, oob1, lval0, lval1, ovf0, ovf1;
    logic [15:0] drop0, drop1;

    always #5 clk = ~clk;

    dm_trace_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LAT(0), .LOG_DEPTH(LOGD)) u0 (
        .clk(clk), .reset(reset), .m_data_addr(addr), .m_data_wdata(wdata),
        .m_data_byteen(byteen), .m_inst_addr(pc), .m_data_rdata(rdata0),
        .mem_busy(busy0), .err_oob(oob0), .log_valid(lval0), .log_ready(ready),
        .log_pc(lpc0), .log_addr(laddr0), .log_data(ldata0),
        .log_overflow(ovf0), .log_drop_cnt(drop0));

    dm_trace_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LAT(1), .LOG_DEPTH(LOGD)) u1 (
        .clk(clk), .reset(reset), .m_data_addr(addr), .m_data_wdata(wdata),
        .m_data_byteen(byteen), .m_inst_addr(pc), .m_data_rdata(rdata1),
        .mem_busy(busy1), .err_oob(oob1), .log_valid(lval1), .log_ready(ready),
        .log_pc(lpc1), .log_addr(laddr1), .log_data(ldata1),
        .log_overflow(ovf1), .log_drop_cnt(drop1));

    // Reference model
    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    logic [31:0] mm [DEPTH];
    rec_t        q[$];
    bit          m_run, m_oob, m_ovf;
    int          m_sweep, m_drop;
    logic [31:0] m_rd1;
    int          n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off / 4) < DEPTH;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] exp_rd();
        return (m_run && in_rng(addr)) ? mm[widx(addr)] : 32'h0;
    endfunction

    task automatic mdl_reset();
        m_run = 0; m_sweep = DEPTH; m_oob = 0; m_ovf = 0; m_drop = 0;
        m_rd1 = '0; q.delete();
    endtask

    task automatic check_outs();
        rec_t h;
        bit   v;
        v = (q.size() > 0);
        if (v) h = q[0];
        else   h = '{pc: 32'h0, addr: 32'h0, data: 32'h0};
        chk("busy0", 32'(busy0), 32'(!m_run));
        chk("busy1", 32'(busy1), 32'(!m_run));
        chk("rdata0", rdata0, exp_rd());
        chk("rdata1", rdata1, m_rd1);
        chk("oob0", 32'(oob0), 32'(m_oob));
        chk("oob1", 32'(oob1), 32'(m_oob));
        chk("lvalid0", 32'(lval0), 32'(v));
        chk("lvalid1", 32'(lval1), 32'(v));
        chk("lpc", lpc0, h.pc);
        chk("laddr", laddr0, h.addr);
        chk("ldata", ldata0, h.data);
        chk("ldata1", ldata1, h.data);
        chk("ovf0", 32'(ovf0), 32'(m_ovf));
        chk("drop0", 32'(drop0), 32'(m_drop));
        chk("drop1", 32'(drop1), 32'(m_drop));
    endtask

    // Effect of one rising edge, computed from the inputs held across it.
    task automatic mdl_edge(input logic [31:0] rdc);
        bit   pop, push;
        rec_t r;
        logic [31:0] w;
        if (!reset) return;
        m_rd1 = rdc;
        if (!m_run) begin
            m_sweep--;
            if (m_sweep == 0) begin
                m_run = 1;
                for (int i = 0; i < DEPTH; i++) mm[i] = '0;
            end
            return;
        end
        pop  = ready && (q.size() > 0);
        push = 0;
        if (byteen != 4'b0) begin
            if (in_rng(addr)) begin
                w = mm[widx(addr)];
                for (int k = 0; k < 4; k++)
                    if (byteen[k]) w[8*k +: 8] = wdata[8*k +: 8];
                mm[widx(addr)] = w;
                r = '{pc: pc, addr: addr & 32'hFFFF_FFFC, data: w};
                if (q.size() == LOGD && !pop) begin
                    m_ovf = 1;
                    if (m_drop < 65535) m_drop++;
                end else push = 1;
            end else m_oob = 1;
        end
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(r);
    endtask

    task automatic step();
        logic [31:0] rdc;
        @(negedge clk);
        check_outs();
        rdc = exp_rd();
        @(posedge clk);
        mdl_edge(rdc);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        mdl_reset();
        repeat (n) step();
        reset = 1'b1;
    endtask

    task automatic wr_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr = a; wdata = d; byteen = be; pc = pc + 32'd4;
        step();
    endtask

    task automatic idle(input int n);
        byteen = 4'b0;
        repeat (n) step();
    endtask

    initial begin
        mdl_reset();
        pc = 32'h0040_0000;
        do_reset(3);
        idle(DEPTH + 2);

        // Preload through the write port, then reset (with a restart mid-sweep).
        ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) wr_req(BASE + 32'(i * 4), $urandom, 4'hF);
        idle(6);
        do_reset(2);
        idle(7);
        do_reset(1);
        idle(DEPTH + 1);
        for (int i = 0; i < DEPTH; i++) begin
            addr = BASE + 32'(i * 4);
            step();
        end

        // Registered read during a write to the same (cleared) word.
        wr_req(BASE + 32'h20, 32'hDEAD_BEEF, 4'hF);
        byteen = 4'b0;
        step();
        chk("rdl1_new", rdata1, 32'hDEAD_BEEF);
        idle(3);

        // Byte merge, records kept queued until checked at the head.
        ready = 1'b0;
        wr_req(BASE + 32'h10, 32'h1122_3344, 4'b1111);
        wr_req(BASE + 32'h12, 32'hAABB_CCDD, 4'b0100);
        chk("merge_rd", rdata0, 32'h11BB_3344);
        chk("merge_head", ldata0, 32'h1122_3344);
        byteen = 4'b0;
        step();
        ready = 1'b1;
        idle(3);

        // Out of range on both sides of the window.
        wr_req(32'h0000_1040, 32'h5555_5555, 4'hF);
        wr_req(32'h0000_0FFC, 32'h6666_6666, 4'hF);
        addr = 32'h0000_1040;
        idle(2);
        chk("oob_flag", 32'(oob0), 32'd1);

        // Overflow: six writes with the consumer stalled.
        ready = 1'b0;
        for (int i = 0; i < 6; i++) wr_req(BASE + 32'(i * 8), 32'hC0DE_0000 + 32'(i), 4'hF);
        idle(1);
        chk("ovf_cnt", 32'(drop0), 32'd2);
        chk("ovf_flag", 32'(ovf0), 32'd1);
        ready = 1'b1;
        idle(6);

        // Full FIFO, write with pop in the same cycle.
        ready = 1'b0;
        for (int i = 0; i < 4; i++) wr_req(BASE + 32'(i * 4), 32'hF00D_0000 + 32'(i), 4'hF);
        ready = 1'b1;
        wr_req(BASE + 32'h3C, 32'hF00D_0004, 4'hF);
        ready = 1'b0;
        idle(1);
        chk("pp_nodrop", 32'(drop0), 32'd2);
        ready = 1'b1;
        idle(6);

        // Random traffic with phases of stalled and eager consumers.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset(2);
                idle(DEPTH);
            end
            if ($urandom_range(0, 4) == 0) addr = $urandom;
            else addr = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            wdata  = $urandom;
            byteen = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
            pc     = $urandom;
            ready  = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                         : ($urandom_range(0, 3) != 0);
            step();
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dm_trace_mem.md
# dm_trace_mem

Parametrised word-organised data memory for the pipelined MIPS core. It serves the M-stage data port: byte-enable merge on write, read data on the same port. It adds three behaviours the bench memory model lacks: a hardware clear sweep after reset, out-of-range detection, and a write-trace FIFO. The trace FIFO lets an on-chip or bench checker drain `PC @ addr <= word` records at its own pace.

## Interface
- `DEPTH`, 4096: memory size in 32-bit words; power of 2, ≥4.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; word-aligned.
- `RD_LAT`, 0: read latency; 0 = combinational, 1 = registered.
- `LOG_DEPTH`, 8: trace FIFO entries; power of 2, ≥2.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `m_data_addr`  in  32  byte address from M stage.
- `m_data_wdata`  in  32  write data, byte lanes already aligned.
- `m_data_byteen`  in  4  byte write enables; 0 = no write.
- `m_inst_addr`  in  32  PC of the M-stage instruction, stored in the trace.
- `m_data_rdata`  out  32  read data.
- `mem_busy`  out  1  clear sweep in progress; the core must stall.
- `err_oob`  out  1  sticky: an out-of-range write was dropped.
- `log_valid`  out  1  trace head valid.
- `log_ready`  in  1  consumer accepts the head.
- `log_pc`, `log_addr`, `log_data`  out  32 each  trace head fields.
- `log_overflow`  out  1  sticky: a trace record was lost.
- `log_drop_cnt`  out  16  lost-record count; saturates at 16'hFFFF.

## Operation
- Offset: `off = m_data_addr - BASE_ADDR` (32-bit wrap).
- Index: `idx = off[log2(DEPTH)+1:2]`.
- In range: `in_range = (off >> 2) < DEPTH`. Address bits [1:0] are ignored.
- FSM, 2 states:
  - CLEAR: entered asynchronously on reset with `clr_ptr = 0`. Each cycle writes 0 to `mem[clr_ptr]` and increments `clr_ptr`. When `clr_ptr == DEPTH-1` is written, the next state is RUN.
  - RUN: normal operation. No exit except reset.
- `mem_busy` = (state == CLEAR).
- Write accept: `wr = RUN & |m_data_byteen & in_range`.
  - Lane k of `mem[idx]` takes `m_data_wdata[8k+7:8k]` if `m_data_byteen[k]`, else keeps its old value.
- Out-of-range write (`RUN & |byteen & ~in_range`): memory unchanged, not traced, `err_oob` set.
- Write attempts during CLEAR: ignored, not traced, no error.
- Read, `RD_LAT=0`: `m_data_rdata = mem[idx]` combinationally.
- Read, `RD_LAT=1`: `m_data_rdata` is registered from `mem[idx]` each cycle.
- Read returns 0 when out of range or in CLEAR.
- Read-during-write to the same word returns the pre-write contents (read-first), for both latencies.
- Trace push on every `wr`. Record fields:
  - `m_inst_addr`;
  - `{m_data_addr[31:2],2'b00}`;
  - the full merged 32-bit word.
- Pop when `log_valid & log_ready`.
- FIFO full and no pop in the same cycle: the record is dropped, `log_overflow` is set, and `log_drop_cnt` increments (saturating).
- FIFO full with a pop in the same cycle: the push is accepted and the count is unchanged.
- Push into an empty FIFO: no fall-through; `log_valid` rises the following cycle.
- Head fields are stable while `log_valid & ~log_ready`.

## Timing
- Reset values (while `reset=0`):
  - `mem_busy=1`;
  - `err_oob=0`, `log_valid=0`, `log_overflow=0`, `log_drop_cnt=0`;
  - `log_*` data outputs = 0;
  - `m_data_rdata=0`;
  - FIFO pointers and count = 0.
- Memory contents are not reset asynchronously; they are cleared by the sweep.
- `mem_busy` falls exactly `DEPTH` rising edges after `reset` deasserts. The first edge writes word 0.
- Reset asserted mid-sweep restarts the sweep from 0.
- Reset asserted mid-RUN discards all FIFO contents and clears both sticky flags.
- Write latency: 1 edge. With `RD_LAT=0`, a read of the written word in the next cycle sees the new data.
- `RD_LAT=1`: `m_data_rdata` reflects the address presented at the previous edge.
- Trace latency: a write at edge N gives `log_valid=1` after edge N (empty FIFO, no backlog).
- Sticky flags clear only by reset.

## Test plan
- Clear sweep, `DEPTH=16`: preload via the write port, release reset → `mem_busy` high for exactly 16 cycles, then every word reads 0.
- Byte merge, `RD_LAT=0`, `BASE_ADDR=0`:
  - write `32'h11223344` to 0x10, byteen 4'b1111;
  - then write `32'hAABBCCDD` to 0x12, byteen 4'b0100;
  - → read 0x10 = `32'h11BB3344`;
  - trace records `(pc, 0x10, 11223344)` and `(pc, 0x10, 11BB3344)`.
- Out of range, `BASE_ADDR=32'h1000`, `DEPTH=16`: write to 0x1040 and to 0x0FFC → memory unchanged, no trace, `err_oob=1`, reads of 0x1040 = 0.
- FIFO overflow, `LOG_DEPTH=4`:
  - `log_ready=0`, six writes → `log_valid=1`, `log_overflow=1`, `log_drop_cnt=2`;
  - then assert `log_ready` → exactly the first four records drain, in order.
- Full push+pop same cycle, `LOG_DEPTH=4`: FIFO full, write with `log_ready=1` → count stays 4, no drop, the new record is last out.
- `RD_LAT=1` read-during-write: word holds `32'h0`, write `32'hDEADBEEF` while reading the same word → `m_data_rdata=0` next cycle, `32'hDEADBEEF` the cycle after.
